// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: round-robin over execute units, multi-beat results hold the grant until eop; 1-cycle registered output.
// Non-writing results are acked immediately; writing results wait for grant; the wb stream has no back-pressure.
module vx_writeback_arb #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int DATAW       = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS-1:0]                 req_valid,
    output logic [NUM_REQS-1:0]                 req_ready,
    input  logic [NUM_REQS*NW_BITS-1:0]         req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]     req_tmask,
    input  logic [NUM_REQS*32-1:0]              req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]         req_rd,
    input  logic [NUM_REQS-1:0]                 req_wb,
    input  logic [NUM_REQS*NUM_THREADS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]                 req_eop,
    output logic                                wb_valid,
    output logic [NW_BITS-1:0]                  wb_wid,
    output logic [NUM_THREADS-1:0]              wb_tmask,
    output logic [31:0]                         wb_PC,
    output logic [NR_BITS-1:0]                  wb_rd,
    output logic [NUM_THREADS*DATAW-1:0]        wb_data,
    output logic                                wb_eop,
    output logic [43:0]                         stall_cycles
);
    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int LW = NUM_THREADS * DATAW;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic [PW-1:0]       r_lock_idx, w_lock_nxt;
    logic [PW-1:0]       w_gnt_idx;
    logic [PW:0]         w_sum;
    logic                w_gnt_vld;
    logic [NUM_REQS-1:0] w_cand, w_gnt_oh;

    logic                r_wb_valid, r_wb_eop;
    logic [NW_BITS-1:0]  r_wb_wid;
    logic [NUM_THREADS-1:0] r_wb_tmask;
    logic [31:0]         r_wb_pc;
    logic [NR_BITS-1:0]  r_wb_rd;
    logic [LW-1:0]       r_wb_data;
    logic [43:0]         r_stall;

    assign w_cand   = req_valid & req_wb;
    assign w_gnt_oh = w_gnt_vld ? (NUM_REQS'(1) << w_gnt_idx) : '0;
    // Non-writing results bypass arbitration entirely.
    assign req_ready = (req_valid & ~req_wb) | w_gnt_oh;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        if (r_state == ST_LOCKED) begin
            w_gnt_vld = w_cand[r_lock_idx];
            w_gnt_idx = r_lock_idx;
        end else begin
            for (int off = 0; off < NUM_REQS; off++) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(off);
                if (w_sum >= (PW+1)'(NUM_REQS))
                    w_sum = w_sum - (PW+1)'(NUM_REQS);
                if (!w_gnt_vld && w_cand[w_sum[PW-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_sum[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_idx;
        if (w_gnt_vld) begin
            // The pointer already moved past k when the lock was taken.
            if (r_state == ST_IDLE)
                w_ptr_nxt = (w_gnt_idx == PW'(NUM_REQS-1)) ? '0 : w_gnt_idx + 1'b1;
            w_state_nxt = req_eop[w_gnt_idx] ? ST_IDLE : ST_LOCKED;
            w_lock_nxt  = w_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_wb_valid <= 1'b0;
            r_wb_eop   <= 1'b0;
            r_wb_wid   <= '0;
            r_wb_tmask <= '0;
            r_wb_pc    <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_stall    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_idx <= w_lock_nxt;
            r_wb_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_wb_eop   <= req_eop[w_gnt_idx];
                r_wb_wid   <= req_wid[w_gnt_idx*NW_BITS +: NW_BITS];
                r_wb_tmask <= req_tmask[w_gnt_idx*NUM_THREADS +: NUM_THREADS];
                r_wb_pc    <= req_PC[w_gnt_idx*32 +: 32];
                r_wb_rd    <= req_rd[w_gnt_idx*NR_BITS +: NR_BITS];
                r_wb_data  <= req_data[w_gnt_idx*LW +: LW];
            end
            if (|(w_cand & ~w_gnt_oh))
                r_stall <= r_stall + 44'd1;
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_eop       = r_wb_eop;
    assign wb_wid       = r_wb_wid;
    assign wb_tmask     = r_wb_tmask;
    assign wb_PC        = r_wb_pc;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign stall_cycles = r_stall;
endmodule

// File: doc/vx_writeback_arb.md
Name: vx_writeback_arb

Overview:
- Commit-side counterpart of the issue stage: collects results from the ALU, LSU, CSR, FPU and GPU units and produces the single per-cycle writeback stream.
- That stream feeds the GPR stage and the scoreboard release.
- Round-robin arbitration across units; a multi-beat response holds the grant until its end-of-packet beat.
- Registered output; one writeback per cycle.

Parameters:
- NUM_REQS, 5, number of execute-unit result ports (index 0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU).
- NUM_THREADS, 4, lanes per warp.
- NW_BITS, 2, warp-id width.
- NR_BITS, 5, register-index width.
- DATAW, 32, per-lane data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQS  per-unit result valid.
- req_ready  out  NUM_REQS  per-unit result accepted.
- req_wid  in  NUM_REQS*NW_BITS  warp id.
- req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- req_PC  in  NUM_REQS*32  instruction PC.
- req_rd  in  NUM_REQS*NR_BITS  destination register.
- req_wb  in  NUM_REQS  result writes a register.
- req_data  in  NUM_REQS*NUM_THREADS*DATAW  per-lane result.
- req_eop  in  NUM_REQS  last beat of this instruction's result.
- wb_valid  out  1  writeback valid.
- wb_wid  out  NW_BITS  warp id.
- wb_tmask  out  NUM_THREADS  thread mask.
- wb_PC  out  32  PC.
- wb_rd  out  NR_BITS  destination register.
- wb_data  out  NUM_THREADS*DATAW  lane data.
- wb_eop  out  1  end of packet.
- stall_cycles  out  44  perf counter.

Behaviour:
- Reset (reset==0 at posedge):
  - wb_valid=0; all wb_* fields 0.
  - Round-robin pointer = 0, so index 0 has top priority on the first arbitration.
  - Lock state IDLE; stall_cycles=0.
  - Reset mid-lock drops the lock and any registered beat; no partial packet is emitted after reset.
- Candidate set: unit i is a candidate when req_valid[i] && req_wb[i].
- Non-writing results (req_valid[i] && !req_wb[i]):
  - req_ready[i]=1 combinationally in the same cycle, independent of arbitration.
  - Several may be consumed concurrently.
  - They never touch the lock or the pointer.
- State IDLE:
  - Grant the first candidate at or after the pointer, in increasing index with wrap-around.
  - req_ready[grant]=1; the beat is registered onto wb_* at the next posedge (latency 1 cycle).
  - Pointer becomes grant+1 modulo NUM_REQS.
  - If the granted beat has req_eop==0, go to LOCKED(grant).
- State LOCKED(k):
  - Only unit k can be granted; all other candidates see req_ready=0.
  - If unit k is not valid in a cycle, wb_valid=0 that cycle and the lock holds.
  - A granted beat with req_eop==1 returns to IDLE. The pointer is not updated during the lock; it was already advanced past k.
- Output register:
  - wb_valid is 1 in exactly the cycle after a grant, else 0.
  - wb_* fields hold their last value when wb_valid=0.
  - wb has no back-pressure; the GPR write port always accepts.
- No candidates: wb_valid=0; pointer and state unchanged.
- req_ready is purely combinational from req_valid, req_wb, the state and the pointer; it never depends on wb_*.
- Handshake: each unit holds req_* stable while req_valid && !req_ready.
- stall_cycles:
  - Increments by 1 each cycle in which at least one candidate is not granted.
  - Counts cycles, not units.
  - Wraps at 2^44.

Test Plan:
- ALU only: req_valid=5'b00001, wb=1, wid=2, rd=7, data lane0=0xDEADBEEF, eop=1 -> req_ready[0]=1 in the same cycle; next cycle wb_valid=1, wb_wid=2, wb_rd=7, lane0=0xDEADBEEF; stall_cycles stays 0.
- ALU and FPU valid every cycle, eop=1, after reset -> grants alternate 0,3,0,3; stall_cycles increments by 1 per cycle.
- LSU multi-beat: LSU beat with eop=0 granted, then ALU becomes valid, then LSU eop=1 two cycles later -> ALU ready stays 0 until the cycle after LSU's eop beat is accepted; a wb_valid=0 bubble appears while LSU is idle mid-packet.
- CSR with wb=0 together with a GPU wb=1 -> both ready in the same cycle; exactly one wb_valid beat (GPU) follows.
- reset driven low while LOCKED(1) with a beat registered -> next cycle wb_valid=0; after release, ALU request granted first (pointer=0).
- All five units valid with wb=1 and eop=1 continuously for 10 cycles -> grant order 0,1,2,3,4,0,...; stall_cycles=10.
